bist_pattern_misr: RTL
======================

Name: bist_pattern_misr

Overview:
- Self-test harness for the combinational optimized netlists: a 14-in/8-out function under evaluation.
- Drives pseudo-random stimulus into the netlist's primary inputs and captures its primary outputs.
- Compacts the captured responses into a MISR signature and compares it against a golden signature taken from the original (pre-optimization) design.
- Used to confirm functional equivalence of each optimized candidate.

Parameters:
- IN_W, 14, width of stimulus vector (netlist primary inputs).
- OUT_W, 8, width of response vector (netlist primary outputs); must be ≤ 16.
- PAT_CNT, 1024, number of patterns per run; legal range 1..65535.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle run request; honoured only in IDLE.
- golden_sig  input  16  expected signature; sampled at the FINISH state.
- pat_out  output  IN_W  stimulus to netlist inputs; registered.
- resp_in  input  OUT_W  netlist outputs; combinational function of pat_out.
- busy  output  1  high in APPLY/CAPTURE/FINISH.
- done  output  1  one-cycle pulse at run end.
- pass  output  1  signature == golden_sig; valid from done, held until next start.
- signature  output  16  current MISR value.
- pat_index  output  16  index of pattern currently applied.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - LFSR = 16'hACE1, MISR = 16'h0000.
  - pat_out = 0, pat_index = 0.
  - busy = done = pass = 0.
- FSM states: IDLE, APPLY, CAPTURE, FINISH.
- IDLE, start=1 sampled at cycle t:
  - LFSR reloads 16'hACE1, MISR clears to 0, pat_index = 0, pass clears.
  - Go to APPLY.
- APPLY, one cycle:
  - pat_out = LFSR[IN_W-1:0]; busy = 1.
  - Gives the combinational netlist one full cycle to settle.
- CAPTURE, one cycle:
  - MISR <= {MISR[14:0], fb_m} ^ zero_extend(resp_in), where fb_m = MISR[15]^MISR[13]^MISR[12]^MISR[10].
  - LFSR <= {LFSR[14:0], fb_l}, where fb_l = LFSR[15]^LFSR[13]^LFSR[12]^LFSR[10].
  - If pat_index == PAT_CNT-1: go to FINISH.
  - Else: pat_index += 1, go to APPLY.
- FINISH, one cycle:
  - done = 1; pass <= (MISR == golden_sig); go to IDLE.
  - busy falls the cycle after done.
- Latency: done is asserted at cycle t+2*PAT_CNT+1.
- Boundary conditions:
  - start while busy: ignored; no restart, no effect on counters.
  - start in the same cycle as done: ignored; start is accepted the following cycle in IDLE.
  - rst mid-run: returns to IDLE with reset values next cycle; no done pulse.
  - PAT_CNT = 1: a single APPLY/CAPTURE pair, then FINISH.
  - pat_index stops at PAT_CNT-1; it never wraps.
- signature and pat_out hold their last values in IDLE until the next start.

Optional Feature:
- Macro: BIST_EXHAUSTIVE_EN.
- When defined:
  - Stimulus is a binary counter: pat_out = pat_index[IN_W-1:0], starting at 0 and incrementing each CAPTURE.
  - Run length is 2^IN_W patterns (16384 for IN_W=14); PAT_CNT is ignored.
  - LFSR logic is removed.
  - pat_index width stays 16.
- When undefined: LFSR stimulus and PAT_CNT run length as above.

Test Plan:
- Reset, then start with PAT_CNT=4 → first APPLY pat_out = 14'h2CE1; second APPLY pat_out = 14'h19C3 (LFSR 16'h59C3); done at t+9.
- resp_in tied to 0, golden_sig = 16'h0000, PAT_CNT=1024 → signature 16'h0000, pass=1, done a single-cycle pulse at t+2049.
- PAT_CNT=2, resp_in constant 8'h01 → signature 16'h0001 after first CAPTURE, 16'h0003 after second; golden 16'h0003 → pass=1; golden 16'h0002 → pass=0.
- start held high throughout a PAT_CNT=4 run → exactly one run; pat_index sequence 0,1,2,3; second run begins only from the cycle after done.
- rst asserted at pattern 2 of a PAT_CNT=8 run → next cycle busy=0, pat_index=0, signature=0, no done pulse; a fresh start then gives the same result as a clean run.
- With BIST_EXHAUSTIVE_EN defined → pat_out runs 0,1,2,…,14'h3FFF; done at t+32769; with resp_in = pat_out[7:0], the signature matches the bench model.

Source files
------------

// File: rtl/bist_pattern_misr.sv
// rtl/bist_pattern_misr.sv - pseudo-random pattern driver with 16-bit MISR response compaction
// Define BIST_EXHAUSTIVE_EN to replace the LFSR with an exhaustive 2^IN_W binary counter.
module bist_pattern_misr #(
    parameter int IN_W    = 14,
    parameter int OUT_W   = 8,
    parameter int PAT_CNT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      golden_sig,
    output logic [IN_W-1:0]  pat_out,
    input  logic [OUT_W-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature,
    output logic [15:0]      pat_index
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    localparam logic [15:0] SEED = 16'hACE1;
`ifdef BIST_EXHAUSTIVE_EN
    localparam logic [15:0] LAST_IDX = 16'((1 << IN_W) - 1);
`else
    localparam logic [15:0] LAST_IDX = 16'(PAT_CNT - 1);
`endif

    state_t          state_q, state_d;
    logic [15:0]     misr_q, misr_d;
    logic [IN_W-1:0] pat_out_q, pat_out_d;
    logic [15:0]     pat_index_q, pat_index_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [15:0]     next_index;
    logic            fb_m;
`ifndef BIST_EXHAUSTIVE_EN
    logic [15:0]     lfsr_q, lfsr_d;
    logic            fb_l;
`endif

    always_comb begin
        state_d     = state_q;
        misr_d      = misr_q;
        pat_out_d   = pat_out_q;
        pat_index_d = pat_index_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        next_index  = pat_index_q + 16'd1;
        fb_m        = misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10];
`ifndef BIST_EXHAUSTIVE_EN
        lfsr_d      = lfsr_q;
        fb_l        = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    misr_d      = 16'h0000;
                    pat_index_d = 16'h0000;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = S_APPLY;
`ifdef BIST_EXHAUSTIVE_EN
                    pat_out_d   = '0;
`else
                    lfsr_d      = SEED;
                    pat_out_d   = SEED[IN_W-1:0];
`endif
                end
            end
            S_APPLY: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                misr_d = {misr_q[14:0], fb_m} ^ 16'(resp_in);
`ifndef BIST_EXHAUSTIVE_EN
                lfsr_d = {lfsr_q[14:0], fb_l};
`endif
                if (pat_index_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    pat_index_d = next_index;
                    state_d     = S_APPLY;
                    // Next stimulus is registered on the way into APPLY so it is stable for the whole cycle.
`ifdef BIST_EXHAUSTIVE_EN
                    pat_out_d   = next_index[IN_W-1:0];
`else
                    pat_out_d   = lfsr_d[IN_W-1:0];
`endif
                end
            end
            S_FINISH: begin
                pass_d  = (misr_q == golden_sig);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            misr_q      <= 16'h0000;
            pat_out_q   <= '0;
            pat_index_q <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
`ifndef BIST_EXHAUSTIVE_EN
            lfsr_q      <= SEED;
`endif
        end else begin
            state_q     <= state_d;
            misr_q      <= misr_d;
            pat_out_q   <= pat_out_d;
            pat_index_q <= pat_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
`ifndef BIST_EXHAUSTIVE_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    // pass is live during the done cycle and latched from then until the next start.
    assign pass      = done_q ? (misr_q == golden_sig) : pass_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign signature = misr_q;
    assign pat_out   = pat_out_q;
    assign pat_index = pat_index_q;
endmodule
